// File: rtl/lbm_result_reader_if.sv
// Bus bundle for the LBM result reader: lattice memory read port plus the host-bound word stream.
// The reader drives the master modport; the memory/host side uses the slave modport.
interface lbm_result_reader_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_WIDTH_F  = 9 * DATA_WIDTH
);
    logic                     mem_rd_en;
    logic [ADDRESS_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH_F-1:0]  mem_rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_last;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/lbm_result_reader.sv
// Post-run readout engine: after FINISHED rises, reads every lattice node and streams its
// nine distributions as words. Optional macro DENSITY_OUT_EN appends rho = sum(f0..f8) per node.
module lbm_result_reader #(
    parameter int GRID_DIM      = 256,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
    parameter int DATA_WIDTH_F  = 9 * DATA_WIDTH,
    parameter int READ_LATENCY  = 2
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                FINISHED,
    lbm_result_reader_if.master lbm_bus,
    output logic                busy,
    output logic                done
);

`ifdef DENSITY_OUT_EN
    localparam int NW = 10;
`else
    localparam int NW = 9;
`endif
    localparam int WORD_W = $clog2(NW);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [WORD_W-1:0]        LAST_WORD = WORD_W'(NW - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);
    localparam logic [LAT_W-1:0]         LAST_LAT  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    state_e                           state_q, state_d;
    logic                             fin_q, fin_prev_q;
    logic [ADDRESS_WIDTH-1:0]         addr_q, addr_d;
    logic [WORD_W-1:0]                word_q, word_d;
    logic [LAT_W-1:0]                 lat_q, lat_d;
    logic [NW-1:0][DATA_WIDTH-1:0]    buf_q, buf_d;
    logic                             mem_rd_en_q, mem_rd_en_d;
    logic [ADDRESS_WIDTH-1:0]         mem_rd_addr_q, mem_rd_addr_d;
    logic                             out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]            out_data_q, out_data_d;
    logic                             out_last_q, out_last_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic                             fin_rise_s;
    logic                             xfer_s;
    logic [DATA_WIDTH_F-1:0]          rd_word_s;

`ifdef DENSITY_OUT_EN
    // Node density: plain sum of the nine distributions, wrapping at DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH-1:0] density_sum(input logic [DATA_WIDTH_F-1:0] f);
        logic [DATA_WIDTH-1:0] acc;
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            acc = acc + f[k*DATA_WIDTH +: DATA_WIDTH];
        end
        return acc;
    endfunction
`endif

    assign rd_word_s  = lbm_bus.mem_rd_data;
    // Both FINISHED flops reset high, so a level held high across reset never looks like a rise.
    assign fin_rise_s = fin_q & ~fin_prev_q;
    assign xfer_s     = out_valid_q & lbm_bus.out_ready;

    // FINISHED sampling and edge-history registers
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            fin_q      <= 1'b1;
            fin_prev_q <= 1'b1;
        end else begin
            fin_q      <= FINISHED;
            fin_prev_q <= fin_q;
        end
    end

    // FSM state, counters, node buffer and registered outputs
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            word_q        <= '0;
            lat_q         <= '0;
            buf_q         <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            word_q        <= word_d;
            lat_q         <= lat_d;
            buf_q         <= buf_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        lat_d      = lat_q;
        buf_d      = buf_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (fin_rise_s) begin
                    state_d = ST_REQ;
                    addr_d  = '0;
                    word_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                lat_d   = '0;
            end
            ST_WAIT: begin
                if (lat_q == LAST_LAT) begin
                    for (int k = 0; k < 9; k++) begin
                        buf_d[k] = rd_word_s[k*DATA_WIDTH +: DATA_WIDTH];
                    end
`ifdef DENSITY_OUT_EN
                    buf_d[9] = density_sum(rd_word_s);
`endif
                    out_data_d = rd_word_s[DATA_WIDTH-1:0];
                    word_d     = '0;
                    state_d    = ST_SEND;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + ADDRESS_WIDTH'(1);
                            state_d = ST_REQ;
                        end
                    end else begin
                        word_d     = word_q + WORD_W'(1);
                        out_data_d = buf_q[word_d];
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                if (!fin_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_rd_en_d   = (state_d == ST_REQ);
        mem_rd_addr_d = addr_d;
        out_valid_d   = (state_d == ST_SEND);
        out_last_d    = (state_d == ST_SEND) && (word_d == LAST_WORD) && (addr_d == LAST_ADDR);
        busy_d        = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_SEND);
        done_d        = (state_d == ST_DONE);
    end

    assign lbm_bus.mem_rd_en   = mem_rd_en_q;
    assign lbm_bus.mem_rd_addr = mem_rd_addr_q;
    assign lbm_bus.out_valid   = out_valid_q;
    assign lbm_bus.out_data    = out_data_q;
    assign lbm_bus.out_last    = out_last_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_lbm_result_reader.sv
// Bench for lbm_result_reader on a 4-node lattice: pipelined memory model plus a word scoreboard.
module tb_lbm_result_reader;
    localparam int GRID = 4;
    localparam int DW   = 32;
    localparam int AW   = $clog2(GRID);
    localparam int DWF  = 9 * DW;
    localparam int RL   = 2;
`ifdef DENSITY_OUT_EN
    localparam int NW = 10;
`else
    localparam int NW = 9;
`endif
    localparam int DUMP_WORDS = GRID * NW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic finished = 1'b0;
    logic busy, done;

    int tests_run = 0;
    int tests_failed = 0;
    int mem_mode = 0;
    int rd_cnt = 0;
    int rd_base = 0;

    logic [DW-1:0] exp_data[$];
    logic          exp_last[$];
    logic [DWF-1:0] pipe [RL];

    lbm_result_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DATA_WIDTH_F(DWF)) bus_if ();

    lbm_result_reader #(
        .GRID_DIM(GRID), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .DATA_WIDTH_F(DWF), .READ_LATENCY(RL)
    ) dut (
        .CLOCK_50(clk), .RESET(rst_n), .FINISHED(finished),
        .lbm_bus(bus_if), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    function automatic logic [DW-1:0] f_val(input int mode, input int addr, input int k);
        logic [DW-1:0] v;
        case (mode)
            0: v = {addr[15:0], k[15:0]};
            1: v = 32'h0100_0000;
            2: v = (k == 0) ? 32'h7FFF_FFFF : ((k == 1) ? 32'h0000_0001 : 32'h0000_0000);
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int mode, input int addr, input int k);
        logic [DW-1:0] acc;
        if (k < 9) return f_val(mode, addr, k);
        acc = 32'h0;
        for (int j = 0; j < 9; j++) acc = acc + f_val(mode, addr, j);
        return acc;
    endfunction

    function automatic logic [DWF-1:0] mem_line(input int mode, input int addr);
        logic [DWF-1:0] l;
        for (int k = 0; k < 9; k++) l[k*DW +: DW] = f_val(mode, addr, k);
        return l;
    endfunction

    // Lattice memory: data appears RL cycles after the strobe; idle slots carry junk.
    always @(posedge clk) begin
        pipe[0] <= bus_if.mem_rd_en ? mem_line(mem_mode, int'(bus_if.mem_rd_addr)) : {9{32'hDEAD_BEEF}};
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        if (bus_if.mem_rd_en) rd_cnt <= rd_cnt + 1;
    end
    assign bus_if.mem_rd_data = pipe[RL-1];

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        for (int a = 0; a < GRID; a++)
            for (int k = 0; k < NW; k++) begin
                exp_data.push_back(exp_word(mem_mode, a, k));
                exp_last.push_back((a == GRID - 1) && (k == NW - 1));
            end
    endtask

    task automatic start_dump();
        finished = 1'b0;
        wait_cycles(3);
        push_dump();
        rd_base = rd_cnt;
        finished = 1'b1;
    endtask

    // Consumes n words against the scoreboard, checking that stalled words hold steady.
    task automatic drain(input int n_words, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        logic [DW-1:0] ed;
        logic el;
        while (got < n_words && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                tests_run++;
                if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== pd || bus_if.out_last !== pl) begin
                    tests_failed++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             bus_if.out_valid, bus_if.out_data, bus_if.out_last, pd, pl);
                end
            end
            if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
                tests_run++;
                if (exp_data.size() == 0) begin
                    tests_failed++;
                    $display("FAIL extra_word: got %h, required no word", bus_if.out_data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    if (bus_if.out_data !== ed || bus_if.out_last !== el) begin
                        tests_failed++;
                        $display("FAIL word%0d: data=%h last=%b, required data=%h last=%b",
                                 got, bus_if.out_data, bus_if.out_last, ed, el);
                    end
                end
                got++;
            end
            stall = (bus_if.out_valid === 1'b1) && (bus_if.out_ready !== 1'b1);
            pd = bus_if.out_data;
            pl = bus_if.out_last;
            @(posedge clk);
            #1;
            bus_if.out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
        end
        tests_run++;
        if (got != n_words) begin
            tests_failed++;
            $display("FAIL drain_timeout: got %0d words, required %0d", got, n_words);
        end
    endtask

    task automatic check_dump_end(input string tag);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done: done=%b busy=%b valid=%b, required 1 0 0", tag, done, busy, bus_if.out_valid);
        end
        tests_run++;
        if (rd_cnt - rd_base != GRID || exp_data.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_reads: reads=%0d left=%0d, required reads=%0d left=0",
                     tag, rd_cnt - rd_base, exp_data.size(), GRID);
        end
    endtask

    task automatic test_reset();
        bit active = 1'b0;
        wait_cycles(3);
        tests_run++;
        if ({bus_if.mem_rd_en, bus_if.mem_rd_addr, bus_if.out_valid, bus_if.out_data,
             bus_if.out_last, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: en=%b valid=%b data=%h busy=%b done=%b, required all 0",
                     bus_if.mem_rd_en, bus_if.out_valid, bus_if.out_data, busy, done);
        end
        rst_n = 1'b1;
        wait_cycles(2);
        finished = 1'b1;
        wait_cycles(6);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy_before: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus_if.mem_rd_en, bus_if.mem_rd_addr, bus_if.out_valid, bus_if.out_data,
             bus_if.out_last, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: en=%b valid=%b data=%h busy=%b done=%b, required all 0",
                     bus_if.mem_rd_en, bus_if.out_valid, bus_if.out_data, busy, done);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || bus_if.mem_rd_en !== 1'b0 || bus_if.out_valid !== 1'b0) active = 1'b1;
        end
        tests_run++;
        if (active) begin
            tests_failed++;
            $display("FAIL reset_no_restart: activity=1, required 0");
        end
    endtask

    task automatic test_basic();
        mem_mode = 0;
        start_dump();
        drain(DUMP_WORDS, 1'b0);
        check_dump_end("basic");
    endtask

    task automatic test_random_ready();
        finished = 1'b0;
        wait_cycles(3);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_clear: done=%b, required 0", done);
        end
        start_dump();
        drain(DUMP_WORDS, 1'b1);
        check_dump_end("random");
    endtask

    task automatic test_finished_glitch();
        bus_if.out_ready = 1'b0;
        start_dump();
        wait_cycles(6);
        finished = 1'b0;
        wait_cycles(2);
        finished = 1'b1;
        drain(DUMP_WORDS, 1'b0);
        wait_cycles(10);
        check_dump_end("glitch");
        finished = 1'b0;
        wait_cycles(3);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_done_clear: done=%b busy=%b, required 0 0", done, busy);
        end
        start_dump();
        drain(DUMP_WORDS, 1'b0);
        check_dump_end("second");
    endtask

    task automatic test_reset_mid_send();
        bus_if.out_ready = 1'b1;
        start_dump();
        drain(2 * NW + 4, 1'b0);
        tests_run++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp_word(0, 2, 4)) begin
            tests_failed++;
            $display("FAIL midsend_pos: valid=%b data=%h, required 1 %h",
                     bus_if.out_valid, bus_if.out_data, exp_word(0, 2, 4));
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_if.out_valid !== 1'b0 || busy !== 1'b0 || bus_if.mem_rd_en !== 1'b0 || bus_if.out_data !== '0) begin
            tests_failed++;
            $display("FAIL midsend_reset: valid=%b busy=%b en=%b data=%h, required 0 0 0 0",
                     bus_if.out_valid, busy, bus_if.mem_rd_en, bus_if.out_data);
        end
        exp_data.delete();
        exp_last.delete();
        wait_cycles(2);
        rst_n = 1'b1;
        start_dump();
        drain(DUMP_WORDS, 1'b0);
        check_dump_end("restart");
    endtask

`ifdef DENSITY_OUT_EN
    task automatic test_density();
        mem_mode = 1;
        start_dump();
        drain(DUMP_WORDS, 1'b1);
        check_dump_end("rho_ones");
        mem_mode = 2;
        start_dump();
        drain(DUMP_WORDS, 1'b0);
        check_dump_end("rho_wrap");
        mem_mode = 0;
    endtask
`endif

    initial begin
        bus_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_random_ready();
        test_finished_glitch();
        test_reset_mid_send();
`ifdef DENSITY_OUT_EN
        test_density();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
